// File: rtl/onehot_decoder_pipe_pkg.sv
// rtl/onehot_decoder_pipe_pkg.sv - shared code constants, entry layout and decode helper
package onehot_decoder_pipe_pkg;

  localparam logic [1:0] CODE_0 = 2'b00;
  localparam logic [1:0] CODE_1 = 2'b01;
  localparam logic [1:0] CODE_2 = 2'b10;
  localparam logic [1:0] CODE_3 = 2'b11;

  localparam int ONEHOT_W = 4;
  localparam int ENTRY_W  = ONEHOT_W + 1;

  typedef struct packed {
    logic                zero;
    logic [ONEHOT_W-1:0] onehot;
  } entry_t;

  // A v=0 word carries no meaningful code, so its code bits are ignored.
  function automatic entry_t decode_word(input logic [1:0] code, input logic v);
    entry_t e;
    e.zero   = 1'b0;
    e.onehot = '0;
    if (!v) begin
      e.zero = 1'b1;
    end else begin
      case (code)
        CODE_0:  e.onehot = 4'b0001;
        CODE_1:  e.onehot = 4'b0010;
        CODE_2:  e.onehot = 4'b0100;
        CODE_3:  e.onehot = 4'b1000;
        default: e.onehot = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_sync_fifo.sv
// rtl/onehot_decoder_pipe_sync_fifo.sv - single-clock FIFO with wrapping pointers and occupancy count
module sync_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// rtl/onehot_decoder_pipe.sv - registered 2-to-4 decoder with output FIFO and zero-word counter
module onehot_decoder_pipe
  import onehot_decoder_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_o1,
  input  logic                in_o2,
  input  logic                in_v,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_zero,
  output logic [CNT_W-1:0]    zero_cnt
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic             w_full;
  logic             w_empty;
  logic [OCC_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  entry_t           w_wentry;
  logic [ENTRY_W-1:0] w_rdata;
  entry_t           w_head;
  logic [CNT_W-1:0] r_zero_cnt;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !w_full;
  assign out_valid = (w_count != '0);

  assign w_push   = in_valid && !w_full;
  assign w_pop    = out_ready && !w_empty;
  assign w_wentry = decode_word({in_o1, in_o2}, in_v);
  assign w_head   = entry_t'(w_rdata);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wentry),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Gate the head so an empty FIFO never shows stale slot contents.
  always_comb begin
    out_onehot = '0;
    out_zero   = 1'b0;
    if (out_valid) begin
      out_onehot = w_head.onehot;
      out_zero   = w_head.zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_cnt <= '0;
    end else if (w_push && !in_v && (r_zero_cnt != {CNT_W{1'b1}})) begin
      r_zero_cnt <= r_zero_cnt + 1'b1;
    end
  end

  assign zero_cnt = r_zero_cnt;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb/tb_onehot_decoder_pipe.sv - randomized scoreboard bench for onehot_decoder_pipe
module tb_onehot_decoder_pipe;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_o1 = 1'b0;
  logic             in_o2 = 1'b0;
  logic             in_v = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_onehot;
  logic             out_zero;
  logic [CNT_W-1:0] zero_cnt;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb[$];
  int model_cnt = 0;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_o1      (in_o1),
    .in_o2      (in_o2),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_zero   (out_zero),
    .zero_cnt   (zero_cnt)
  );

  function automatic logic [4:0] ref_entry(input int code, input logic v);
    if (!v) return 5'b1_0000;
    return {1'b0, 4'(1 << code)};
  endfunction

  // Monitor: compare the cycle's state first, then record this cycle's handshakes.
  always @(negedge clk) begin
    logic [4:0] exp_head;
    logic [4:0] act_head;
    act_head = {out_zero, out_onehot};
    exp_head = (sb.size() == 0) ? 5'b0 : sb[0];

    checks++;
    if (zero_cnt !== CNT_W'(model_cnt)) begin
      errors++;
      $display("FAIL zero_cnt t=%0t actual=%0d required=%0d", $time, zero_cnt, model_cnt);
    end
    checks++;
    if (in_ready !== (sb.size() != DEPTH)) begin
      errors++;
      $display("FAIL in_ready t=%0t actual=%b required=%b", $time, in_ready, sb.size() != DEPTH);
    end
    checks++;
    if (out_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL out_valid t=%0t actual=%b required=%b", $time, out_valid, sb.size() != 0);
    end
    checks++;
    if (act_head !== exp_head) begin
      errors++;
      $display("FAIL head t=%0t actual zero=%b onehot=%b required zero=%b onehot=%b",
               $time, act_head[4], act_head[3:0], exp_head[4], exp_head[3:0]);
    end
    if (sb.size() > DEPTH) begin
      errors++;
      $display("FAIL occupancy t=%0t actual=%0d required<=%0d", $time, sb.size(), DEPTH);
    end

    if (rst) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) begin
        sb.push_back(ref_entry({in_o1, in_o2}, in_v));
        if (!in_v && model_cnt < CNT_MAX) model_cnt++;
      end
    end
  end

  // Caller is positioned just after a rising edge; returns likewise, in_valid left high.
  task automatic send(input int code, input logic v);
    int waited;
    in_valid = 1'b1;
    {in_o1, in_o2} = 2'(code);
    in_v = v;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        errors++;
        $display("FAIL send_timeout t=%0t actual=stalled required=accept", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) send(c, 1'b1);
    send(3, 1'b0);
    idle(3);

    out_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    fork
      send(3, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    for (int i = 0; i < 5; i++) send(i % 4, 1'b0);
    idle(3);

    out_ready = 1'b0;
    send(0, 1'b1);
    send(3, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(2, 1'b1);
    idle(3);

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send($urandom_range(0, 3), 1'($urandom_range(0, 3) != 0));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 400; i++) begin
          out_ready = 1'($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join

    out_ready = 1'b1;
    in_valid = 1'b0;
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Registered 2-to-4 decoder, the receive-side counterpart of the team's 4-to-2 priority encoder (outputs o1/o2/v). Accepts encoded words {o1,o2,v} on a valid/ready stream, expands each to a 4-bit one-hot vector, buffers results in a small FIFO and presents them on a second valid/ready stream. Also counts "no input active" words (v=0) for diagnostics. Sits between encoder-side logic and any consumer of one-hot select lines.

## Interface
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the zero-word counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept a word this cycle.
- in_o1  in  1  code MSB (encoder o1).
- in_o2  in  1  code LSB (encoder o2).
- in_v  in  1  encoder valid flag; 0 = no input bit was set.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  downstream accepts head this cycle.
- out_onehot  out  4  decoded vector at FIFO head.
- out_zero  out  1  head entry came from a v=0 word.
- zero_cnt  out  CNT_W  saturating count of accepted v=0 words.

## Operation
- Accept (push) when in_valid && in_ready. Pop when out_valid && out_ready.
- Decode of accepted word, code = {in_o1,in_o2}: v=1: 00→0001, 01→0010, 10→0100, 11→1000; out_zero=0. v=0: onehot 0000, out_zero=1, code bits ignored.
- Every accepted word produces exactly one FIFO entry, order preserved.
- zero_cnt increments by 1 on each accepted v=0 word; saturates at 2^CNT_W−1 (no wrap). Unchanged on non-accepted words.
- FIFO: read/write pointers of log2(DEPTH) bits wrap modulo DEPTH; occupancy counter 0..DEPTH.
- in_ready = (count != DEPTH), from registered state only (no combinational path from out_ready).
- Full and popping in same cycle: in_ready still 0 that cycle; push blocked; slot available next cycle.
- Push and pop in same cycle, 0<count<DEPTH: count unchanged, both pointers advance.
- Empty: out_valid=0; out_onehot=0000, out_zero=0 (output gated, not stale data).
- in_valid with in_ready=0: word not consumed, no counter change; upstream holds it.
- Reset (any time, including mid-transfer): FIFO flushed, in-flight data discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_onehot=0000, out_zero=0, zero_cnt=0, pointers/count=0.
- Latency: word accepted at edge N appears at head with out_valid=1 after edge N (visible cycle N+1) if FIFO was empty. No same-cycle bypass.
- Throughput: one word/cycle sustained when out_ready held high.
- zero_cnt reflects a v=0 word one cycle after its acceptance edge.
- out_valid/out_onehot/out_zero held stable while out_valid && !out_ready.

## Structure
- Shared package: code constants (CODE_0..CODE_3 = 2'b00..2'b11), onehot width 4, entry layout {zero,onehot[3:0]} width 5.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the 5-bit entries; decode logic and saturating counter in top level.

## Test plan
- Reset then push codes 00,01,10,11 with v=1, out_ready=1 → out_onehot 0001,0010,0100,1000 on consecutive cycles, first one cycle after first accept; zero_cnt=0.
- Push v=0 with code 11 → out_onehot=0000, out_zero=1, zero_cnt=1.
- out_ready=0, push 3 words (DEPTH=2) → in_ready=0 after 2 accepts, third word held; head stable; raise out_ready → all three emerge in order.
- Full FIFO, out_ready=1 and in_valid=1 same cycle → no push that cycle, push next cycle; count never exceeds 2.
- CNT_W=2, push 5 v=0 words → zero_cnt sequence 1,2,3,3,3.
- Fill FIFO, assert rst for one cycle mid-stream → out_valid=0, in_ready=1, zero_cnt=0 next cycle; subsequent code 10 decodes to 0100.
